// File: rtl/logic_reduce_stream.sv
// Folds a burst of words into one word with AND/NAND/OR/XOR and returns the
// result, the beat count and an overflow flag on a valid/ready output.
module logic_reduce_stream #(
    parameter int WIDTH   = 16,
    parameter int MAX_LEN = 8,
    localparam int CW     = $clog2(MAX_LEN + 1)
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_in_data,
    input  logic             i_in_last,
    input  logic [1:0]       i_op,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_out_data,
    output logic [CW-1:0]    o_out_count,
    output logic             o_out_overflow
);

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, HOLD} state_t;

    localparam logic [1:0] OP_NAND = 2'b01;
    localparam logic [1:0] OP_OR   = 2'b10;
    localparam logic [1:0] OP_XOR  = 2'b11;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_acc;
    logic [CW-1:0]    r_cnt;
    logic [1:0]       r_op;
    logic             r_ovf;

    logic             w_accept;
    logic [CW-1:0]    w_cnt_inc;
    logic             w_at_max;
    logic [WIDTH-1:0] w_fold;

    assign w_accept  = i_in_valid && o_in_ready;
    assign w_cnt_inc = r_cnt + CW'(1);
    assign w_at_max  = (w_cnt_inc == CW'(MAX_LEN));

    // NAND folds as AND; the inversion is applied only on the way out.
    always_comb begin
        w_fold = r_acc & i_in_data;
        case (r_op)
            OP_OR:   w_fold = r_acc | i_in_data;
            OP_XOR:  w_fold = r_acc ^ i_in_data;
            default: w_fold = r_acc & i_in_data;
        endcase
    end

    always_comb begin
        w_next         = r_state;
        o_in_ready     = 1'b1;
        o_out_valid    = 1'b0;
        o_out_data     = '0;
        o_out_count    = '0;
        o_out_overflow = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (i_in_last)         w_next = HOLD;
                    else if (MAX_LEN == 1) w_next = DRAIN;
                    else                   w_next = ACCUM;
                end
            end
            ACCUM: begin
                if (w_accept) begin
                    if (i_in_last)     w_next = HOLD;
                    else if (w_at_max) w_next = DRAIN;
                end
            end
            DRAIN: begin
                if (w_accept && i_in_last) w_next = HOLD;
            end
            HOLD: begin
                o_in_ready     = 1'b0;
                o_out_valid    = 1'b1;
                o_out_data     = (r_op == OP_NAND) ? ~r_acc : r_acc;
                o_out_count    = r_cnt;
                o_out_overflow = r_ovf;
                if (i_out_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_op    <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                case (r_state)
                    IDLE: begin
                        r_acc <= i_in_data;
                        r_cnt <= CW'(1);
                        r_op  <= i_op;
                        r_ovf <= !i_in_last && (MAX_LEN == 1);
                    end
                    ACCUM: begin
                        r_acc <= w_fold;
                        r_cnt <= w_cnt_inc;
                        r_ovf <= !i_in_last && w_at_max;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
